// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared register indices and arming states for gpio_ctrl
package gpio_pkg;

    localparam int GPIO_MAX_WIDTH = 32;

    localparam logic [2:0] GPIO_OUT_IDX      = 3'd0;
    localparam logic [2:0] GPIO_IN_IDX       = 3'd1;
    localparam logic [2:0] GPIO_DIR_IDX      = 3'd2;
    localparam logic [2:0] GPIO_IRQ_EN_IDX   = 3'd3;
    localparam logic [2:0] GPIO_RISE_SEL_IDX = 3'd4;
    localparam logic [2:0] GPIO_FALL_SEL_IDX = 3'd5;
    localparam logic [2:0] GPIO_PEND_IDX     = 3'd6;

    typedef enum logic {
        WARMUP = 1'b0,
        ARMED  = 1'b1
    } arm_state_t;

endpackage

// File: rtl/gpio_ctrl_if.sv
// rtl/gpio_ctrl_if.sv - data-memory bus slice seen by the gpio peripheral
interface gpio_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  sel;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output sel, output we, output addr, output wdata, input rdata);
    modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/gpio_sync.sv
// rtl/gpio_sync.sv - multi-stage flop synchroniser for asynchronous inputs
module gpio_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);
    logic [STAGES-1:0][WIDTH-1:0] r_chain;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[STAGES-1];
endmodule

// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - memory-mapped GPIO with direction, synchroniser and edge interrupts
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int GPIO_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    gpio_ctrl_if.slave            bus,
    input  logic [GPIO_WIDTH-1:0] i_gpio_port_in,
    output logic [GPIO_WIDTH-1:0] o_gpio_port_out,
    output logic [GPIO_WIDTH-1:0] o_gpio_port_oe,
    output logic                  o_irq
);
    logic [GPIO_WIDTH-1:0] r_out, r_dir, r_irq_en, r_rise_sel, r_fall_sel, r_pend, r_prev;
    logic [GPIO_WIDTH-1:0] w_sync, w_wdata, w_w1c, w_rise, w_fall, w_evt;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [2:0]            w_idx;
    logic                  w_wr;
    logic                  w_unused;
    arm_state_t            r_state, w_state_nxt;
    logic [2:0]            r_cnt, w_cnt_nxt;

    gpio_sync #(.STAGES(SYNC_STAGES), .WIDTH(GPIO_WIDTH)) u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_gpio_port_in),
        .o_sync  (w_sync)
    );

    assign w_idx    = bus.addr[4:2];
    assign w_wr     = bus.sel & bus.we;
    assign w_wdata  = bus.wdata[GPIO_WIDTH-1:0];
    assign w_unused = ^{bus.addr, bus.wdata};

    assign w_rise = w_sync & ~r_prev;
    assign w_fall = ~w_sync & r_prev;
    // Events stay masked until the synchroniser has flushed its reset zeros.
    assign w_evt  = (r_state == ARMED) ? ((w_rise & r_rise_sel) | (w_fall & r_fall_sel)) : '0;
    assign w_w1c  = (w_wr && w_idx == GPIO_PEND_IDX) ? w_wdata : '0;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= WARMUP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            WARMUP: begin
                if (r_cnt == 3'(SYNC_STAGES)) w_state_nxt = ARMED;
                else                          w_cnt_nxt   = r_cnt + 3'd1;
            end
            ARMED: w_state_nxt = ARMED;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_out      <= '0;
            r_dir      <= '0;
            r_irq_en   <= '0;
            r_rise_sel <= '0;
            r_fall_sel <= '0;
            r_pend     <= '0;
            r_prev     <= '0;
        end else begin
            if (w_wr) begin
                case (w_idx)
                    GPIO_OUT_IDX:      r_out      <= w_wdata;
                    GPIO_DIR_IDX:      r_dir      <= w_wdata;
                    GPIO_IRQ_EN_IDX:   r_irq_en   <= w_wdata;
                    GPIO_RISE_SEL_IDX: r_rise_sel <= w_wdata;
                    GPIO_FALL_SEL_IDX: r_fall_sel <= w_wdata;
                    default:           ;
                endcase
            end
            // A new edge in the same cycle as a clear keeps the bit set.
            r_pend <= (r_pend & ~w_w1c) | w_evt;
            r_prev <= w_sync;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (bus.sel) begin
            case (w_idx)
                GPIO_OUT_IDX:      w_rdata = DATA_WIDTH'(r_out);
                GPIO_IN_IDX:       w_rdata = DATA_WIDTH'(w_sync);
                GPIO_DIR_IDX:      w_rdata = DATA_WIDTH'(r_dir);
                GPIO_IRQ_EN_IDX:   w_rdata = DATA_WIDTH'(r_irq_en);
                GPIO_RISE_SEL_IDX: w_rdata = DATA_WIDTH'(r_rise_sel);
                GPIO_FALL_SEL_IDX: w_rdata = DATA_WIDTH'(r_fall_sel);
                GPIO_PEND_IDX:     w_rdata = DATA_WIDTH'(r_pend);
                default:           w_rdata = '0;
            endcase
        end
    end

    assign bus.rdata       = w_rdata;
    assign o_gpio_port_out = r_out & r_dir;
    assign o_gpio_port_oe  = r_dir;
    assign o_irq           = |(r_pend & r_irq_en);
endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - directed self-checking bench for gpio_ctrl
module tb_gpio_ctrl;
    logic       clk;
    logic       rst;
    logic [7:0] pin_in;
    logic [7:0] pin_out;
    logic [7:0] pin_oe;
    logic       irq;
    int         tests_run;
    int         tests_failed;

    gpio_ctrl_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    gpio_ctrl #(.GPIO_WIDTH(8), .SYNC_STAGES(2), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .bus             (bus),
        .i_gpio_port_in  (pin_in),
        .o_gpio_port_out (pin_out),
        .o_gpio_port_oe  (pin_oe),
        .o_irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d);
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = {idx, 2'b00}; bus.wdata = d;
        @(posedge clk);
        #1;
        bus.sel = 1'b0; bus.we = 1'b0; bus.wdata = '0;
    endtask

    task automatic rd(input logic [2:0] idx, output logic [31:0] d);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = {idx, 2'b00};
        #1;
        d = bus.rdata;
        bus.sel = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(1);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), d);
            tests_run++;
            if (d !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_word%0d: got %h expected 00000000", i, d);
            end
        end
        tests_run++;
        if (pin_out !== 8'h00) begin tests_failed++; $display("FAIL reset_out: got %h expected 00", pin_out); end
        tests_run++;
        if (pin_oe !== 8'h00) begin tests_failed++; $display("FAIL reset_oe: got %h expected 00", pin_oe); end
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq: got %b expected 0", irq); end
    endtask

    task automatic test_outputs();
        logic [31:0] d;
        cyc(1);
        wr(3'd2, 32'h0F);
        wr(3'd0, 32'hFF);
        tests_run++;
        if (pin_oe !== 8'h0F) begin tests_failed++; $display("FAIL out_oe: got %h expected 0f", pin_oe); end
        tests_run++;
        if (pin_out !== 8'h0F) begin tests_failed++; $display("FAIL out_pins: got %h expected 0f", pin_out); end
        rd(3'd0, d);
        tests_run++;
        if (d !== 32'hFF) begin tests_failed++; $display("FAIL out_readback: got %h expected 000000ff", d); end
        cyc(1);
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd7, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL word7_read: got %h expected 00000000", d); end
        rd(3'd0, d);
        tests_run++;
        if (d !== 32'hFF) begin tests_failed++; $display("FAIL word7_side_effect: got %h expected 000000ff", d); end
        cyc(1);
        wr(3'd2, 32'hFFFF_FF30);
        rd(3'd2, d);
        tests_run++;
        if (d !== 32'h30) begin tests_failed++; $display("FAIL dir_upper_bits: got %h expected 00000030", d); end
        tests_run++;
        if (pin_out !== 8'h30) begin tests_failed++; $display("FAIL out_and_dir: got %h expected 30", pin_out); end
        cyc(1);
        wr(3'd2, 32'h0);
        wr(3'd0, 32'h0);
    endtask

    task automatic test_sync();
        logic [31:0] d;
        pin_in = 8'h02;
        cyc(1);
        rd(3'd1, d);
        tests_run++;
        if (d !== 32'h00) begin tests_failed++; $display("FAIL sync_stage1: got %h expected 00000000", d); end
        cyc(1);
        rd(3'd1, d);
        tests_run++;
        if (d !== 32'h02) begin tests_failed++; $display("FAIL sync_stage2: got %h expected 00000002", d); end
        pin_in = 8'h00;
        cyc(4);
    endtask

    task automatic test_irq();
        logic [31:0] d;
        wr(3'd4, 32'h02);
        wr(3'd3, 32'h02);
        pin_in = 8'h02;
        cyc(2);
        rd(3'd6, d);
        tests_run++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            tests_failed++; $display("FAIL irq_early: got pend %h irq %b expected 0 0", d, irq);
        end
        cyc(1);
        rd(3'd6, d);
        tests_run++;
        if (d !== 32'h02) begin tests_failed++; $display("FAIL irq_pend: got %h expected 00000002", d); end
        tests_run++;
        if (irq !== 1'b1) begin tests_failed++; $display("FAIL irq_raise: got %b expected 1", irq); end
        cyc(1);
        wr(3'd6, 32'h02);
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_w1c: got %b expected 0", irq); end
        pin_in = 8'h00;
        cyc(5);
        rd(3'd6, d);
        tests_run++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            tests_failed++; $display("FAIL irq_no_fall: got pend %h irq %b expected 0 0", d, irq);
        end
        cyc(1);
        wr(3'd3, 32'h00);
        wr(3'd4, 32'h04);
        pin_in = 8'h04;
        cyc(4);
        rd(3'd6, d);
        tests_run++;
        if (d !== 32'h04 || irq !== 1'b0) begin
            tests_failed++; $display("FAIL pend_masked: got pend %h irq %b expected 4 0", d, irq);
        end
        cyc(1);
        wr(3'd3, 32'h04);
        tests_run++;
        if (irq !== 1'b1) begin tests_failed++; $display("FAIL late_enable: got %b expected 1", irq); end
        wr(3'd6, 32'hFF);
        wr(3'd3, 32'h00);
        wr(3'd4, 32'h00);
        pin_in = 8'h00;
        cyc(4);
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        wr(3'd4, 32'h01);
        wr(3'd5, 32'h01);
        pin_in = 8'h01;
        cyc(4);
        rd(3'd6, d);
        tests_run++;
        if (d !== 32'h01) begin tests_failed++; $display("FAIL both_edge_rise: got %h expected 00000001", d); end
        cyc(1);
        pin_in = 8'h00;
        cyc(2);
        wr(3'd6, 32'h01);
        rd(3'd6, d);
        tests_run++;
        if (d !== 32'h01) begin tests_failed++; $display("FAIL set_wins: got %h expected 00000001", d); end
        cyc(1);
        wr(3'd6, 32'h01);
        rd(3'd6, d);
        tests_run++;
        if (d !== 32'h00) begin tests_failed++; $display("FAIL w1c_plain: got %h expected 00000000", d); end
    endtask

    task automatic test_reset_hold();
        logic [31:0] d;
        cyc(1);
        rst = 1'b0;
        pin_in = 8'hFF;
        cyc(3);
        rst = 1'b1;
        wr(3'd4, 32'hFF);
        wr(3'd3, 32'hFF);
        for (int i = 0; i < 10; i++) begin
            rd(3'd6, d);
            tests_run++;
            if (d !== 32'h0 || irq !== 1'b0) begin
                tests_failed++; $display("FAIL hold_no_rise_c%0d: got pend %h irq %b expected 0 0", i, d, irq);
            end
            cyc(1);
        end
        pin_in = 8'h00;
        cyc(4);
        pin_in = 8'hFF;
        cyc(4);
        rd(3'd6, d);
        tests_run++;
        if (d !== 32'hFF || irq !== 1'b1) begin
            tests_failed++; $display("FAIL midrun_setup: got pend %h irq %b expected ff 1", d, irq);
        end
        cyc(1);
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL async_rst_irq: got %b expected 0", irq); end
        rd(3'd6, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL async_rst_pend: got %h expected 00000000", d); end
        cyc(2);
        rst = 1'b1;
        cyc(1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        pin_in       = 8'h00;
        bus.sel      = 1'b0;
        bus.we       = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;
        test_reset();
        test_outputs();
        test_sync();
        test_irq();
        test_set_wins();
        test_reset_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
